// File: rtl/vec_pkg.sv
// Shared constants, operand types and fetch FSM state encoding for the
// vector operand-fetch stage.
package vec_pkg;

   localparam int LANES   = 24;
   localparam int LANE_W  = 8;
   localparam int VW      = LANES * LANE_W;
   localparam int REG_AW  = 4;
   localparam int FUNCT_W = 3;

   typedef logic [VW-1:0]      vreg_t;
   typedef logic [FUNCT_W-1:0] funct_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD1,
      S_RD2,
      S_CAP,
      S_ISSUE
   } fetch_state_t;

endpackage

// File: rtl/vec_lane_bcast.sv
// Replicates one lane-wide scalar across every lane of a vector.
// Only present when VS_BROADCAST_EN is defined (its sole user is gated on it).
`ifdef VS_BROADCAST_EN
module vec_lane_bcast #(
   parameter int LANES  = vec_pkg::LANES,
   parameter int LANE_W = vec_pkg::LANE_W
) (
   input  logic [LANE_W-1:0]       scalar,
   output logic [LANES*LANE_W-1:0] vec
);

   assign vec = {LANES{scalar}};

endmodule
`endif

// File: rtl/vec_operand_fetch.sv
// Operand fetch/issue stage ahead of the vector ALU: two reads on one RF port.
// Optional VS_BROADCAST_EN: vector-scalar instructions broadcast the scalar as op2.
module vec_operand_fetch #(
   parameter int LANES   = vec_pkg::LANES,
   parameter int LANE_W  = vec_pkg::LANE_W,
   parameter int REG_AW  = vec_pkg::REG_AW,
   parameter int FUNCT_W = vec_pkg::FUNCT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [REG_AW-1:0]       in_rs1,
   input  logic [REG_AW-1:0]       in_rs2,
   input  logic [REG_AW-1:0]       in_rd,
   input  logic [FUNCT_W-1:0]      in_funct,
   input  logic                    in_vs,
   input  logic [LANE_W-1:0]       in_scalar,
   output logic                    rf_rd_en,
   output logic [REG_AW-1:0]       rf_rd_addr,
   input  logic [LANES*LANE_W-1:0] rf_rd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_op1,
   output logic [LANES*LANE_W-1:0] out_op2,
   output logic [FUNCT_W-1:0]      out_funct,
   output logic [REG_AW-1:0]       out_rd
);

   import vec_pkg::*;

   localparam int VW = LANES * LANE_W;

   fetch_state_t      state, state_nxt;
   logic [REG_AW-1:0] rs1_q, rs2_q;
   logic              accept;
   logic              bcast_sel;
   logic [VW-1:0]     op2_bcast;

`ifdef VS_BROADCAST_EN
   logic              vs_q;
   logic [LANE_W-1:0] scalar_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q     <= 1'b0;
         scalar_q <= '0;
      end else if (accept) begin
         vs_q     <= in_vs;
         scalar_q <= in_scalar;
      end
   end

   assign bcast_sel = vs_q;

   vec_lane_bcast #(
      .LANES  (LANES),
      .LANE_W (LANE_W)
   ) u_bcast (
      .scalar (scalar_q),
      .vec    (op2_bcast)
   );
`else
   logic unused_vs;
   assign unused_vs = ^{in_vs, in_scalar};
   assign bcast_sel = 1'b0;
   assign op2_bcast = '0;
`endif

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      rf_rd_en   = 1'b0;
      rf_rd_addr = '0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = S_RD1;
            end
         end
         S_RD1: begin
            rf_rd_en   = 1'b1;
            rf_rd_addr = rs1_q;
            state_nxt  = S_RD2;
         end
         S_RD2: begin
            // Vector-scalar form skips the second read entirely.
            if (bcast_sel) begin
               state_nxt = S_ISSUE;
            end else begin
               rf_rd_en   = 1'b1;
               rf_rd_addr = rs2_q;
               state_nxt  = S_CAP;
            end
         end
         S_CAP: state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  accept    = 1'b1;
                  state_nxt = S_RD1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign out_valid = (state == S_ISSUE);

   // Operand/issue registers: RF data lands one cycle after each read request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rs1_q     <= '0;
         rs2_q     <= '0;
         out_funct <= '0;
         out_rd    <= '0;
         out_op1   <= '0;
         out_op2   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            out_funct <= in_funct;
            out_rd    <= in_rd;
         end
         if (state == S_RD2) begin
            out_op1 <= rf_rd_data;
            if (bcast_sel)
               out_op2 <= op2_bcast;
         end
         if (state == S_CAP)
            out_op2 <= rf_rd_data;
      end
   end

endmodule

// File: tb/tb_vec_operand_fetch.sv
// Scoreboard bench for vec_operand_fetch: randomized instructions against a
// transaction-level model of reads, latency and issued operands.
module tb_vec_operand_fetch;
   import vec_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [REG_AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   funct_t            in_funct = '0;
   logic              in_vs = 1'b0;
   logic [LANE_W-1:0] in_scalar = '0;
   logic              rf_rd_en;
   logic [REG_AW-1:0] rf_rd_addr;
   vreg_t             rf_rd_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   vreg_t             out_op1, out_op2;
   funct_t            out_funct;
   logic [REG_AW-1:0] out_rd;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   vec_operand_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_rd      (in_rd),
      .in_funct   (in_funct),
      .in_vs      (in_vs),
      .in_scalar  (in_scalar),
      .rf_rd_en   (rf_rd_en),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op1    (out_op1),
      .out_op2    (out_op2),
      .out_funct  (out_funct),
      .out_rd     (out_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic vreg_t rand_vec();
      vreg_t v;
      for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Register file model: synchronous read, garbage on idle cycles.
   vreg_t rf [16];
   always @(posedge clk) rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : rand_vec();

   typedef struct {
      vreg_t             op1;
      vreg_t             op2;
      funct_t            funct;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              vs;
      int                acc;
      int                lat;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
      end
   endtask

   // Monitor / scoreboard
   logic rst_chk = 1'b0;
   always @(negedge clk) begin
      logic exp_ov, exp_en, vs_eff;
      logic [REG_AW-1:0] exp_addr;
      int d;
      exp_t e;
      if (rst) begin
         q.delete();
         rst_chk = 1'b1;
      end else begin
         if (rst_chk) begin
            chk("reset_out_valid", {191'd0, out_valid}, '0);
            chk("reset_in_ready", {191'd0, in_ready}, {191'd0, 1'b1});
            chk("reset_rf_rd_en", {191'd0, rf_rd_en}, '0);
            chk("reset_op1", out_op1, '0);
            chk("reset_op2", out_op2, '0);
            chk("reset_funct_rd", {185'd0, out_funct, out_rd}, '0);
            rst_chk = 1'b0;
         end
         exp_ov   = 1'b0;
         exp_en   = 1'b0;
         exp_addr = '0;
         if (q.size() > 0) begin
            d      = cyc - q[0].acc;
            exp_ov = (d >= q[0].lat);
            if (d == 1) begin
               exp_en   = 1'b1;
               exp_addr = q[0].rs1;
            end else if (d == 2 && !q[0].vs) begin
               exp_en   = 1'b1;
               exp_addr = q[0].rs2;
            end
         end
         chk("out_valid", {191'd0, out_valid}, {191'd0, exp_ov});
         chk("in_ready", {191'd0, in_ready},
             {191'd0, (q.size() == 0) || (exp_ov && out_ready)});
         chk("rf_rd_en", {191'd0, rf_rd_en}, {191'd0, exp_en});
         chk("rf_rd_addr", {188'd0, rf_rd_addr}, {188'd0, exp_addr});
         if (out_valid && q.size() > 0) begin
            chk("op1", out_op1, q[0].op1);
            chk("op2", out_op2, q[0].op2);
            chk("funct_rd", {185'd0, out_funct, out_rd}, {185'd0, q[0].funct, q[0].rd});
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
`ifdef VS_BROADCAST_EN
            vs_eff = in_vs;
`else
            vs_eff = 1'b0;
`endif
            e.op1   = rf[in_rs1];
            e.op2   = vs_eff ? {LANES{in_scalar}} : rf[in_rs2];
            e.funct = in_funct;
            e.rd    = in_rd;
            e.rs1   = in_rs1;
            e.rs2   = in_rs2;
            e.vs    = vs_eff;
            e.acc   = cyc;
            e.lat   = vs_eff ? 3 : 4;
            q.push_back(e);
         end
      end
   end

   task automatic issue(input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2,
                        input logic [REG_AW-1:0] d, input funct_t f,
                        input logic vs, input logic [LANE_W-1:0] sc);
      int n;
      in_valid  = 1'b1;
      in_rs1    = r1;
      in_rs2    = r2;
      in_rd     = d;
      in_funct  = f;
      in_vs     = vs;
      in_scalar = sc;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout at cycle %0d: in_ready 0 expected 1 within 60 cycles", cyc);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_rs1    = REG_AW'($urandom);
      in_rs2    = REG_AW'($urandom);
      in_rd     = REG_AW'($urandom);
      in_funct  = FUNCT_W'($urandom);
      in_vs     = 1'($urandom);
      in_scalar = LANE_W'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic rnd_done;
   initial begin
      int n;
      for (int i = 0; i < 16; i++) rf[i] = rand_vec();
      rf[3] = {LANES{8'h11}};
      rf[5] = {LANES{8'h22}};

      // Reset held two cycles
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2);

      // Basic vector-vector fetch
      issue(4'd3, 4'd5, 4'd7, 3'b000, 1'b0, 8'h00);
      idle(6);

      // Stall in issue, then back-to-back accept on release
      out_ready = 1'b0;
      issue(4'd5, 4'd3, 4'd2, 3'b101, 1'b0, 8'h00);
      n = 0;
      while (!out_valid && n < 20) begin
         n++;
         @(posedge clk);
      end
      #1;
      idle(5);
      out_ready = 1'b1;
      issue(4'd3, 4'd3, 4'd9, 3'b010, 1'b0, 8'h00);
      idle(6);

      // Reset while the second read is in flight
      issue(4'd1, 4'd2, 4'd4, 3'b011, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(8);

      // Vector-scalar form (broadcast only when the feature is built in)
      issue(4'd3, 4'd5, 4'd9, 3'b101, 1'b1, 8'hA5);
      idle(6);

      // Randomized traffic with random backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               issue(REG_AW'($urandom), REG_AW'($urandom), REG_AW'($urandom),
                     FUNCT_W'($urandom), 1'($urandom), LANE_W'($urandom));
               if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
